// File: rtl/tmds_pkg.sv
// Shared definitions for the TMDS encoder: period modes, fixed symbol codes,
// TERC4 lookup and the popcount used by both encoding stages.
package tmds_pkg;

  typedef enum logic [1:0] {
    MODE_CTL = 2'd0,
    MODE_VID = 2'd1,
    MODE_DI  = 2'd2,
    MODE_GB  = 2'd3
  } tmds_mode_e;

  localparam logic [9:0] CTL_CODE_00 = 10'h354;
  localparam logic [9:0] CTL_CODE_01 = 10'h0AB;
  localparam logic [9:0] CTL_CODE_10 = 10'h154;
  localparam logic [9:0] CTL_CODE_11 = 10'h2AB;

  localparam logic [9:0] GB_CODE_CH02 = 10'h2CC;
  localparam logic [9:0] GB_CODE_CH1  = 10'h133;

  // HDMI 1.4 TERC4 table, symbol bit 0 is the first bit on the wire.
  function automatic logic [9:0] terc4_code(input logic [3:0] nib);
    logic [9:0] code;
    code = 10'h29C;
    case (nib)
      4'h0: code = 10'h29C;
      4'h1: code = 10'h263;
      4'h2: code = 10'h2E4;
      4'h3: code = 10'h2E2;
      4'h4: code = 10'h171;
      4'h5: code = 10'h11E;
      4'h6: code = 10'h18E;
      4'h7: code = 10'h13C;
      4'h8: code = 10'h2CC;
      4'h9: code = 10'h139;
      4'hA: code = 10'h19C;
      4'hB: code = 10'h2C6;
      4'hC: code = 10'h28E;
      4'hD: code = 10'h271;
      4'hE: code = 10'h163;
      4'hF: code = 10'h2C3;
      default: code = 10'h29C;
    endcase
    return code;
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] b);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, b[i]};
    return n;
  endfunction

endpackage

// File: rtl/tmds_lane_encoder.sv
// One TMDS lane: stage 1 builds the transition-minimised word, stage 2 applies
// DC balance in video mode or emits the fixed control/TERC4/guard-band symbol.
module tmds_lane_encoder
  import tmds_pkg::*;
#(
  parameter int LANE  = 0,
  parameter int CNT_W = 5
) (
  input  logic                    pixel_clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic [1:0]              mode,
  input  logic [7:0]              data_in,
  input  logic [1:0]              ctl_in,
  input  logic [3:0]              terc4_in,
  output logic [9:0]              data_out,
  output logic signed [CNT_W-1:0] disp_out
);

  localparam logic signed [CNT_W-1:0] TWO   = CNT_W'(2);
  localparam logic signed [CNT_W-1:0] EIGHT = CNT_W'(8);

  logic [3:0]              n1_in;
  logic                    use_xnor;
  logic [8:0]              q_m_d, q_m_q;
  logic [1:0]              ctl_q;
  logic [3:0]              terc4_q;
  logic signed [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]              sym_d;
  logic [3:0]              n1_q, n0_q;
  logic signed [CNT_W-1:0] n1_s, diff;
  logic                    qm8, cnt_zero, cnt_pos, cnt_neg;
  tmds_mode_e              mode_e;

  assign n1_in    = popcount8(data_in);
  assign use_xnor = (n1_in > 4'd4) || ((n1_in == 4'd4) && !data_in[0]);

  always_comb begin
    q_m_d    = '0;
    q_m_d[0] = data_in[0];
    for (int i = 1; i < 8; i++)
      q_m_d[i] = use_xnor ? ~(q_m_d[i-1] ^ data_in[i]) : (q_m_d[i-1] ^ data_in[i]);
    q_m_d[8] = ~use_xnor;
  end

  assign mode_e   = tmds_mode_e'(mode);
  assign qm8      = q_m_q[8];
  assign n1_q     = popcount8(q_m_q[7:0]);
  assign n0_q     = 4'd8 - n1_q;
  assign n1_s     = $signed({{(CNT_W-4){1'b0}}, n1_q});
  assign diff     = n1_s + n1_s - EIGHT;  // n1 - n0
  assign cnt_zero = (cnt_q == '0);
  assign cnt_neg  = cnt_q[CNT_W-1];
  assign cnt_pos  = !cnt_neg && !cnt_zero;

  // NOTE: outputs get defaults before the case so no path can infer a latch.
  always_comb begin
    sym_d = CTL_CODE_00;
    cnt_d = '0;
    case (mode_e)
      MODE_CTL: begin
        case (ctl_q)
          2'b00:   sym_d = CTL_CODE_00;
          2'b01:   sym_d = CTL_CODE_01;
          2'b10:   sym_d = CTL_CODE_10;
          default: sym_d = CTL_CODE_11;
        endcase
      end
      MODE_VID: begin
        if (cnt_zero || (n1_q == n0_q)) begin
          sym_d = {~qm8, qm8, qm8 ? q_m_q[7:0] : ~q_m_q[7:0]};
          cnt_d = qm8 ? cnt_q + diff : cnt_q - diff;
        end else if ((cnt_pos && (n1_q > n0_q)) || (cnt_neg && (n0_q > n1_q))) begin
          sym_d = {1'b1, qm8, ~q_m_q[7:0]};
          cnt_d = cnt_q - diff + (qm8 ? TWO : '0);
        end else begin
          sym_d = {1'b0, qm8, q_m_q[7:0]};
          cnt_d = cnt_q + diff - (qm8 ? '0 : TWO);
        end
      end
      MODE_DI: sym_d = terc4_code(terc4_q);
      MODE_GB: sym_d = (LANE == 1) ? GB_CODE_CH1 : GB_CODE_CH02;
      default: ;
    endcase
  end

  // NOTE: pipeline state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      q_m_q    <= '0;
      ctl_q    <= 2'b00;
      terc4_q  <= '0;
      data_out <= CTL_CODE_00;
      cnt_q    <= '0;
    end else if (ce) begin
      q_m_q    <= q_m_d;
      ctl_q    <= ctl_in;
      terc4_q  <= terc4_in;
      data_out <= sym_d;
      cnt_q    <= cnt_d;
    end
  end

  assign disp_out = cnt_q;

endmodule

// File: rtl/tmds_multi_encoder.sv
// NUM_CH TMDS lanes encoded in lockstep; the stage-1 mode register is shared
// so every lane switches period type on the same symbol.
module tmds_multi_encoder
  import tmds_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 5
) (
  input  logic                    pixel_clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic [1:0]              mode,
  input  logic [8*NUM_CH-1:0]     data_in,
  input  logic [2*NUM_CH-1:0]     ctl_in,
  input  logic [4*NUM_CH-1:0]     terc4_in,
  output logic [10*NUM_CH-1:0]    data_out,
  output logic [CNT_W*NUM_CH-1:0] disp_out
);

  tmds_mode_e mode_q;

  always_ff @(posedge pixel_clk) begin
    if (rst)     mode_q <= MODE_CTL;
    else if (ce) mode_q <= tmds_mode_e'(mode);
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    tmds_lane_encoder #(
      .LANE  (k),
      .CNT_W (CNT_W)
    ) u_lane (
      .pixel_clk (pixel_clk),
      .rst       (rst),
      .ce        (ce),
      .mode      (mode_q),
      .data_in   (data_in[8*k +: 8]),
      .ctl_in    (ctl_in[2*k +: 2]),
      .terc4_in  (terc4_in[4*k +: 4]),
      .data_out  (data_out[10*k +: 10]),
      .disp_out  (disp_out[CNT_W*k +: CNT_W])
    );
  end

endmodule

// File: tb/tb_tmds_multi_encoder.sv
// Scoreboard bench: stimulus pushes expected symbols, a monitor pops them as
// the two-stage pipeline delivers; a 1-lane instance shadows lane 0.
module tb_tmds_multi_encoder;

  localparam int NCH = 3;
  localparam int CW  = 5;

  logic           pixel_clk;
  logic           rst;
  logic           ce;
  logic [1:0]     mode;
  logic [23:0]    data_in;
  logic [5:0]     ctl_in;
  logic [11:0]    terc4_in;
  logic [29:0]    data_out3;
  logic [14:0]    disp_out3;
  logic [9:0]     data_out1;
  logic [4:0]     disp_out1;
  logic           issue;

  tmds_multi_encoder #(.NUM_CH(NCH), .CNT_W(CW)) dut3 (
    .pixel_clk (pixel_clk),
    .rst       (rst),
    .ce        (ce),
    .mode      (mode),
    .data_in   (data_in),
    .ctl_in    (ctl_in),
    .terc4_in  (terc4_in),
    .data_out  (data_out3),
    .disp_out  (disp_out3)
  );

  tmds_multi_encoder #(.NUM_CH(1), .CNT_W(CW)) dut1 (
    .pixel_clk (pixel_clk),
    .rst       (rst),
    .ce        (ce),
    .mode      (mode),
    .data_in   (data_in[7:0]),
    .ctl_in    (ctl_in[1:0]),
    .terc4_in  (terc4_in[3:0]),
    .data_out  (data_out1),
    .disp_out  (disp_out1)
  );

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  typedef struct {
    logic [1:0]  m;
    logic [23:0] d;
    logic [29:0] sym;
    logic [14:0] disp;
  } exp_t;

  exp_t sb[$];
  int   mcnt[NCH];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [9:0] terc_tab[16] = '{10'h29C, 10'h263, 10'h2E4, 10'h2E2,
                               10'h171, 10'h11E, 10'h18E, 10'h13C,
                               10'h2CC, 10'h139, 10'h19C, 10'h2C6,
                               10'h28E, 10'h271, 10'h163, 10'h2C3};
  logic [9:0] ctl_tab[4]   = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic ref_vid(input logic [7:0] d, inout int cnt, output logic [9:0] s);
    int         n1, a, b;
    logic [8:0] qm;
    logic       xn;
    n1 = $countones(d);
    xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = ~xn;
    a = $countones(qm[7:0]);
    b = 8 - a;
    if (cnt == 0 || a == b) begin
      s   = qm[8] ? {2'b01, qm[7:0]} : {2'b10, ~qm[7:0]};
      cnt = cnt + (qm[8] ? a - b : b - a);
    end else if ((cnt > 0 && a > b) || (cnt < 0 && b > a)) begin
      s   = {1'b1, qm[8], ~qm[7:0]};
      cnt = cnt + (qm[8] ? 2 : 0) + b - a;
    end else begin
      s   = {1'b0, qm[8], qm[7:0]};
      cnt = cnt + a - b - (qm[8] ? 0 : 2);
    end
  endtask

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] q, d;
    q    = s[9] ? ~s[7:0] : s[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return d;
  endfunction

  function automatic int sdisp(input logic [4:0] v);
    return int'($signed(v));
  endfunction

  // Drive one pixel; when enabled, push the expectation (hand values if given).
  task automatic pix_x(input logic [1:0] m, input logic [23:0] d, input logic [5:0] c,
                       input logic [11:0] t, input logic e, input logic hand,
                       input logic [29:0] hsym, input logic [14:0] hdisp);
    exp_t       it;
    logic [9:0] s;
    @(negedge pixel_clk);
    mode = m; data_in = d; ctl_in = c; terc4_in = t; ce = e; issue = e;
    if (e) begin
      it.m = m;
      it.d = d;
      for (int k = 0; k < NCH; k++) begin
        case (m)
          2'd0:    begin s = ctl_tab[c[2*k +: 2]]; mcnt[k] = 0; end
          2'd1:    ref_vid(d[8*k +: 8], mcnt[k], s);
          2'd2:    begin s = terc_tab[t[4*k +: 4]]; mcnt[k] = 0; end
          default: begin s = (k == 1) ? 10'h133 : 10'h2CC; mcnt[k] = 0; end
        endcase
        it.sym[10*k +: 10] = s;
        it.disp[5*k +: 5]  = 5'(mcnt[k]);
      end
      if (hand) begin
        it.sym  = hsym;
        it.disp = hdisp;
      end
      sb.push_back(it);
    end
  endtask

  task automatic pix(input logic [1:0] m, input logic [23:0] d, input logic [5:0] c,
                     input logic [11:0] t, input logic e);
    pix_x(m, d, c, t, e, 1'b0, '0, '0);
  endtask

  task automatic pix_h(input logic [1:0] m, input logic [23:0] d, input logic [5:0] c,
                       input logic [11:0] t, input logic [29:0] hsym, input logic [14:0] hdisp);
    pix_x(m, d, c, t, 1'b1, 1'b1, hsym, hdisp);
  endtask

  task automatic chk_idle(input string name);
    for (int k = 0; k < NCH; k++) begin
      check({name, "_sym"}, 32'(data_out3[10*k +: 10]), 32'h354);
      check({name, "_disp"}, 32'(disp_out3[5*k +: 5]), 32'h0);
    end
    check({name, "_sym1"}, 32'(data_out1), 32'h354);
    check({name, "_disp1"}, 32'(disp_out1), 32'h0);
  endtask

  task automatic do_reset(input logic e);
    @(negedge pixel_clk);
    rst = 1'b1; ce = e; mode = 2'd1; issue = 1'b0; data_in = 24'($urandom);
    repeat (3) begin
      @(posedge pixel_clk);
      #1 chk_idle("rst_hold");
    end
    @(negedge pixel_clk);
    rst = 1'b0; ce = 1'b1; mode = 2'd0; ctl_in = '0; issue = 1'b0;
    @(posedge pixel_clk);
    #1 chk_idle("rst_first");
    for (int k = 0; k < NCH; k++) mcnt[k] = 0;
  endtask

  // Monitor: tracks which pipeline slots carry issued pixels and checks them.
  initial begin : monitor
    logic v1, v2, pop_now, s_rst, s_ce, have_last;
    exp_t it, last;
    v1 = 1'b0; v2 = 1'b0; have_last = 1'b0;
    forever begin
      @(posedge pixel_clk);
      s_rst = rst; s_ce = ce; pop_now = 1'b0;
      if (s_rst) begin
        v1 = 1'b0; v2 = 1'b0; have_last = 1'b0;
        sb.delete();
      end else if (s_ce) begin
        v2 = v1; v1 = issue; pop_now = v2;
        if (!pop_now) have_last = 1'b0;
      end
      #1;
      if (pop_now) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          it = sb.pop_front();
          for (int k = 0; k < NCH; k++) begin
            check($sformatf("sym_l%0d", k), 32'(data_out3[10*k +: 10]), 32'(it.sym[10*k +: 10]));
            check($sformatf("disp_l%0d", k), 32'(disp_out3[5*k +: 5]), 32'(it.disp[5*k +: 5]));
            if (it.m == 2'd1) begin
              check($sformatf("decode_l%0d", k), 32'(decode(data_out3[10*k +: 10])),
                    32'(it.d[8*k +: 8]));
              check($sformatf("bound_l%0d", k),
                    32'((sdisp(disp_out3[5*k +: 5]) <= 10) && (sdisp(disp_out3[5*k +: 5]) >= -10)),
                    32'd1);
            end
          end
          check("sym_1ch", 32'(data_out1), 32'(it.sym[9:0]));
          check("disp_1ch", 32'(disp_out1), 32'(it.disp[4:0]));
          last = it;
          have_last = 1'b1;
        end
      end else if (!s_rst && !s_ce && have_last) begin
        check("hold_sym", 32'(data_out3), 32'(last.sym));
        check("hold_disp", 32'(disp_out3), 32'(last.disp));
        check("hold_sym_1ch", 32'(data_out1), 32'(last.sym[9:0]));
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst = 1'b1; ce = 1'b1; mode = 2'd1; issue = 1'b0;
    data_in = '0; ctl_in = '0; terc4_in = '0;
    for (int k = 0; k < NCH; k++) mcnt[k] = 0;

    do_reset(1'b1);

    // Video 0x00 from cnt=0, then disparity clear and control sweep.
    pix_h(2'd1, 24'h0, 6'h0, 12'h0, {3{10'h100}}, {3{5'h18}});
    pix_h(2'd1, 24'h0, 6'h0, 12'h0, {3{10'h3FF}}, {3{5'h02}});
    pix_h(2'd1, 24'h0, 6'h0, 12'h0, {3{10'h100}}, {3{5'h1A}});
    pix_h(2'd0, 24'h0, 6'b000000, 12'h0, {3{10'h354}}, '0);
    pix_h(2'd1, 24'h0, 6'h0, 12'h0, {3{10'h100}}, {3{5'h18}});
    pix_h(2'd0, 24'h0, 6'b010101, 12'h0, {3{10'h0AB}}, '0);
    pix_h(2'd1, 24'h0, 6'h0, 12'h0, {3{10'h100}}, {3{5'h18}});
    pix_h(2'd0, 24'h0, 6'b101010, 12'h0, {3{10'h154}}, '0);
    pix_h(2'd0, 24'h0, 6'b111111, 12'h0, {3{10'h2AB}}, '0);
    // TERC4 and guard band.
    pix_h(2'd2, 24'h0, 6'h0, 12'hF0F, {10'h2C3, 10'h29C, 10'h2C3}, '0);
    pix_h(2'd2, 24'h0, 6'h0, 12'h0F0, {10'h29C, 10'h2C3, 10'h29C}, '0);
    pix_h(2'd3, 24'h0, 6'h0, 12'h0, {10'h2CC, 10'h133, 10'h2CC}, '0);
    pix_h(2'd1, 24'hFFFFFF, 6'h0, 12'h0, {3{10'h200}}, {3{5'h18}});

    // Random video, uninterrupted.
    for (int i = 0; i < 6000; i++) pix(2'd1, 24'($urandom), 6'h0, 12'h0, 1'b1);

    // Random video with stalls.
    for (int i = 0; i < 2000; i++)
      pix(2'd1, 24'($urandom), 6'h0, 12'h0, 1'($urandom_range(0, 9) < 7));

    // Reset mid-video, asserted while stalled.
    pix(2'd1, 24'($urandom), 6'h0, 12'h0, 1'b1);
    pix(2'd1, 24'($urandom), 6'h0, 12'h0, 1'b1);
    do_reset(1'b0);

    // Random period types with stalls, then video again.
    for (int i = 0; i < 1500; i++)
      pix(2'($urandom_range(0, 3)), 24'($urandom), 6'($urandom), 12'($urandom),
          1'($urandom_range(0, 9) < 8));
    for (int i = 0; i < 2000; i++) pix(2'd1, 24'($urandom), 6'h0, 12'h0, 1'b1);

    // Drain the pipeline.
    for (int i = 0; i < 3; i++) pix(2'd0, 24'h0, 6'h0, 12'h0, 1'b1);
    @(negedge pixel_clk);
    issue = 1'b0;
    repeat (3) @(negedge pixel_clk);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
